switch_allocator: RTL and testbench

- Per-router output-port allocator. Arbitrates route-reservation requests from every input port's head-flit buffer.
- Grants each output to at most one input at a time, round-robin among contenders.
- Holds the grant until the owning input signals tail-flit release.
- Drives the crossbar select and returns the reservation status pulse to the requesting port.

---
 rtl/noc_alloc_pkg.sv | 16 +
 rtl/switch_allocator_if.sv | 38 +++
 rtl/switch_allocator_rr_arbiter.sv | 37 +++
 rtl/switch_allocator.sv | 137 +++++++++++++
 tb/tb_switch_allocator.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/noc_alloc_pkg.sv
// Shared types and constants for the NoC switch allocator slice.
// State encodings, index-width helper and default port count.
package noc_alloc_pkg;

   localparam int PORTS_DEF = 5;

   typedef enum logic {
      IDLE     = 1'b0,
      RESERVED = 1'b1
   } allocState_t;

   function automatic int idxWidth(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Route-reservation bundle between input-port buffers and the allocator.
// master = port/crossbar side, slave = allocator.
interface switch_allocator_if
   import noc_alloc_pkg::*;
#(
   parameter int PORTS         = PORTS_DEF,
   parameter int REQUEST_WIDTH = 3
);

   logic [PORTS-1:0]               routeReserveRequestValid;
   logic [PORTS*REQUEST_WIDTH-1:0] routeReserveRequest;
   logic [PORTS-1:0]               routeRelease;
   logic [PORTS-1:0]               routeReserveStatus;
   logic [PORTS-1:0]               outputReserved;
   logic [PORTS*REQUEST_WIDTH-1:0] outputSelect;
   logic [PORTS-1:0]               inputGranted;

   modport master (
      output routeReserveRequestValid,
      output routeReserveRequest,
      output routeRelease,
      input  routeReserveStatus,
      input  outputReserved,
      input  outputSelect,
      input  inputGranted
   );

   modport slave (
      input  routeReserveRequestValid,
      input  routeReserveRequest,
      input  routeRelease,
      output routeReserveStatus,
      output outputReserved,
      output outputSelect,
      output inputGranted
   );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first
// requester strictly above ptr, wrapping to index 0.
module rr_arbiter
   import noc_alloc_pkg::*;
#(
   parameter int PORTS = PORTS_DEF,
   parameter int PW    = idxWidth(PORTS)
) (
   input  logic [PORTS-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [PORTS-1:0] grant
);

   logic [PORTS-1:0] reqHi;
   logic [PORTS-1:0] pick;
   logic             done;

   always_comb begin
      reqHi = '0;
      for (int j = 0; j < PORTS; j++) begin
         reqHi[j] = req[j] && (j > int'(ptr));
      end
      pick = (|reqHi) ? reqHi : req;
   end

   always_comb begin
      grant = '0;
      done  = 1'b0;
      for (int j = 0; j < PORTS; j++) begin
         if (!done && pick[j]) begin
            grant[j] = 1'b1;
            done     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_allocator.sv
// Per-router output-port allocator with hold-until-tail reservations.
// Define SWITCH_ALLOC_RELEASE_BYPASS_EN to regrant on the release edge.
module switch_allocator
   import noc_alloc_pkg::*;
#(
   parameter int PORTS         = PORTS_DEF,
   parameter int REQUEST_WIDTH = 3
) (
   input logic         clk,
   input logic         rst,
   switch_allocator_if.slave bus
);

   localparam int RW = REQUEST_WIDTH;

   allocState_t      state     [PORTS];
   allocState_t      stateNext [PORTS];
   logic [RW-1:0]    owner     [PORTS];
   logic [RW-1:0]    ownerNext [PORTS];
   logic [RW-1:0]    pointer   [PORTS];
   logic [RW-1:0]    pointerNext [PORTS];
   logic [RW-1:0]    reqSlice  [PORTS];
   logic [PORTS-1:0] eligible  [PORTS];
   logic [PORTS-1:0] grant     [PORTS];
   logic [PORTS-1:0] granted;
   logic [PORTS-1:0] grantedNext;
   logic [PORTS-1:0] status;
   logic [PORTS-1:0] statusNext;
   logic [PORTS-1:0] releasing;
   logic [PORTS-1:0] freeOut;
   logic [PORTS-1:0] win;

   for (genvar i = 0; i < PORTS; i++) begin : g_slice
      assign reqSlice[i] = bus.routeReserveRequest[i*RW +: RW];
   end

   always_comb begin
      releasing = '0;
      for (int o = 0; o < PORTS; o++) begin
         for (int i = 0; i < PORTS; i++) begin
            if (state[o] == RESERVED && owner[o] == RW'(i)
                && bus.routeRelease[i])
               releasing[o] = 1'b1;
         end
      end
   end

   // The releasing owner still has granted set, so it stays ineligible.
   always_comb begin
      for (int o = 0; o < PORTS; o++) begin
`ifdef SWITCH_ALLOC_RELEASE_BYPASS_EN
         freeOut[o] = (state[o] == IDLE) || releasing[o];
`else
         freeOut[o] = (state[o] == IDLE);
`endif
         eligible[o] = '0;
         for (int i = 0; i < PORTS; i++) begin
            eligible[o][i] = bus.routeReserveRequestValid[i]
                             && reqSlice[i] == RW'(o)
                             && !granted[i]
                             && freeOut[o];
         end
      end
   end

   for (genvar o = 0; o < PORTS; o++) begin : g_arb
      rr_arbiter #(
         .PORTS (PORTS),
         .PW    (RW)
      ) u_arb (
         .req   (eligible[o]),
         .ptr   (pointer[o]),
         .grant (grant[o])
      );
      assign win[o] = |grant[o];
      assign bus.outputReserved[o] = (state[o] == RESERVED);
      assign bus.outputSelect[o*RW +: RW] = owner[o];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int o = 0; o < PORTS; o++) begin
            state[o]   <= IDLE;
            owner[o]   <= '0;
            pointer[o] <= RW'(PORTS - 1);
         end
         granted <= '0;
         status  <= '0;
      end else begin
         for (int o = 0; o < PORTS; o++) begin
            state[o]   <= stateNext[o];
            owner[o]   <= ownerNext[o];
            pointer[o] <= pointerNext[o];
         end
         granted <= grantedNext;
         status  <= statusNext;
      end
   end

   always_comb begin
      for (int o = 0; o < PORTS; o++) begin
         stateNext[o] = state[o];
         unique case (1'b1)
            win[o]:       stateNext[o] = RESERVED;
            releasing[o]: stateNext[o] = IDLE;
            default:      stateNext[o] = state[o];
         endcase
      end
   end

   always_comb begin
      grantedNext = granted;
      statusNext  = '0;
      for (int o = 0; o < PORTS; o++) begin
         ownerNext[o]   = owner[o];
         pointerNext[o] = pointer[o];
         for (int i = 0; i < PORTS; i++) begin
            if (releasing[o] && owner[o] == RW'(i))
               grantedNext[i] = 1'b0;
         end
      end
      for (int o = 0; o < PORTS; o++) begin
         for (int i = 0; i < PORTS; i++) begin
            if (grant[o][i]) begin
               ownerNext[o]   = RW'(i);
               pointerNext[o] = RW'(i);
               grantedNext[i] = 1'b1;
               statusNext[i]  = 1'b1;
            end
         end
      end
   end

   assign bus.routeReserveStatus = status;
   assign bus.inputGranted       = granted;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator, PORTS=5.
// Expectations follow SWITCH_ALLOC_RELEASE_BYPASS_EN when defined.
module tb_switch_allocator;
   import noc_alloc_pkg::*;

   localparam int P  = 5;
   localparam int RW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nVec = 0;
   int   nMis = 0;

   always #5 clk = ~clk;

   switch_allocator_if #(.PORTS(P), .REQUEST_WIDTH(RW)) bus ();

   switch_allocator #(
      .PORTS         (P),
      .REQUEST_WIDTH (RW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nMis++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setReq(input int i, input int o);
      bus.routeReserveRequestValid[i] = 1'b1;
      bus.routeReserveRequest[i*RW +: RW] = RW'(o);
   endtask

   task automatic clrReq(input int i);
      bus.routeReserveRequestValid[i] = 1'b0;
   endtask

   task automatic relPulse(input int i);
      bus.routeRelease[i] = 1'b1;
      step();
      bus.routeRelease = '0;
   endtask

   function automatic logic [RW-1:0] sel(input int o);
      return RW'(bus.outputSelect >> (o*RW));
   endfunction

   initial begin
      int order [4] = '{0, 1, 3, 0};
      bus.routeReserveRequestValid = '0;
      bus.routeReserveRequest      = '0;
      bus.routeRelease             = '0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      for (int c = 0; c < 10; c++) begin
         chk("idle", {bus.routeReserveStatus, bus.outputReserved,
                      bus.inputGranted}, 32'h0);
         step();
      end

      setReq(2, 4);
      step();
      chk("single_status", bus.routeReserveStatus, 32'b00100);
      chk("single_resv", bus.outputReserved, 32'b10000);
      chk("single_sel", sel(4), 32'd2);
      chk("single_gnt", bus.inputGranted, 32'b00100);
      step();
      chk("hold_status1", bus.routeReserveStatus, 32'h0);
      step();
      chk("hold_status2", bus.routeReserveStatus, 32'h0);
      clrReq(2);
      relPulse(2);
      chk("single_free", {bus.outputReserved, bus.inputGranted}, 32'h0);

      setReq(0, 1);
      setReq(1, 1);
      setReq(3, 1);
      step();
      for (int n = 0; n < 4; n++) begin
         for (int k = 0; k < 4 && bus.routeReserveStatus == '0; k++)
            step();
         chk($sformatf("rr_status%0d", n), bus.routeReserveStatus,
             32'(1 << order[n]));
         chk($sformatf("rr_sel%0d", n), sel(1), 32'(order[n]));
         step();
         step();
         if (n == 3) begin
            clrReq(0);
            clrReq(1);
            clrReq(3);
         end
         relPulse(order[n]);
      end
      step();
      chk("rr_free", {bus.outputReserved, bus.inputGranted}, 32'h0);

      setReq(1, 2);
      step();
      chk("rel_first", bus.routeReserveStatus, 32'b00010);
      setReq(3, 2);
      step();
      step();
      chk("rel_wait", bus.routeReserveStatus, 32'h0);
      clrReq(1);
      relPulse(1);
`ifdef SWITCH_ALLOC_RELEASE_BYPASS_EN
      chk("rel_regrant", bus.routeReserveStatus, 32'b01000);
`else
      chk("rel_bubble", bus.routeReserveStatus, 32'h0);
      chk("rel_idle", bus.outputReserved, 32'h0);
      step();
      chk("rel_regrant", bus.routeReserveStatus, 32'b01000);
`endif
      chk("rel_sel", sel(2), 32'd3);
      clrReq(3);
      relPulse(3);

      setReq(0, 3);
      setReq(4, 0);
      setReq(2, 6);
      step();
      chk("par_status", bus.routeReserveStatus, 32'b10001);
      chk("par_resv", bus.outputReserved, 32'b01001);
      chk("par_sel3", sel(3), 32'd0);
      chk("par_sel0", sel(0), 32'd4);
      clrReq(0);
      clrReq(4);
      step();
      step();
      chk("illegal_gnt", bus.inputGranted, 32'b10001);
      bus.routeRelease = 5'b10001;
      step();
      bus.routeRelease = '0;
      chk("par_free", bus.outputReserved, 32'h0);

      setReq(1, 1);
      setReq(3, 3);
      step();
      chk("uturn_status", bus.routeReserveStatus, 32'b01010);
      chk("uturn_resv", bus.outputReserved, 32'b01010);
      clrReq(1);
      clrReq(3);
      rst = 1'b1;
      step();
      chk("rst_clear", {bus.routeReserveStatus, bus.outputReserved,
                        bus.inputGranted}, 32'h0);
      rst = 1'b0;
      step();
      chk("rst_after", {bus.routeReserveStatus, bus.inputGranted}, 32'h0);

      setReq(0, 1);
      step();
      chk("post_rst_gnt", bus.routeReserveStatus, 32'b00001);
      clrReq(0);
      relPulse(2);
      chk("spurious_resv", bus.outputReserved, 32'b00010);
      chk("spurious_gnt", bus.inputGranted, 32'b00001);
      chk("spurious_sel", sel(1), 32'd0);
      clrReq(2);
      relPulse(0);
      chk("final_free", bus.outputReserved, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
